// File: rtl/conv2d_layer.sv
// Streaming 2D convolution layer: loads one image into an internal buffer, then
// computes OUT_CH channels per output position with a K*K-cycle MAC sweep.
module conv2d_layer #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int IMG_W      = 35,
  parameter int IMG_H      = 35,
  parameter int K          = 5,
  parameter int OUT_CH     = 6,
  parameter int RELU_EN    = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [OUT_CH*DATA_WIDTH-1:0]   bias_in,
  input  logic                           img_valid,
  output logic                           img_ready,
  input  logic [DATA_WIDTH-1:0]          img_data,
  output logic [$clog2(K*K)-1:0]         wt_addr,
  input  logic [OUT_CH*DATA_WIDTH-1:0]   wt_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUT_CH*DATA_WIDTH-1:0]   out_data,
  output logic                           busy,
  output logic                           done
);
  localparam int DW    = DATA_WIDTH;
  localparam int KK    = K * K;
  localparam int OUT_W = IMG_W - K + 1;
  localparam int OUT_H = IMG_H - K + 1;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int PA    = $clog2(NPIX);
  localparam int TW    = $clog2(KK);
  localparam int CW    = $clog2(KK + 3);
  localparam int AW    = 2 * DW + $clog2(KK);

  localparam logic [CW-1:0] C_LAST_TAP = CW'(KK - 1);
  localparam logic [CW-1:0] C_MAC_END  = CW'(KK + 1);
  localparam logic [CW-1:0] C_RESULT   = CW'(KK + 2);
  localparam logic [PA-1:0] P_KM1      = PA'(K - 1);
  localparam logic [PA-1:0] P_OWM1     = PA'(OUT_W - 1);
  localparam logic [PA-1:0] P_OHM1     = PA'(OUT_H - 1);
  localparam logic [PA-1:0] P_LASTPIX  = PA'(NPIX - 1);
  localparam logic [PA-1:0] P_IMG_W    = PA'(IMG_W);

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD_IMG, ST_CONV, ST_OUT, ST_DONE} state_t;

  state_t                 r_state;
  logic [PA-1:0]          r_waddr, r_ox, r_oy, r_kx, r_ky;
  logic [CW-1:0]          r_cnt;
  logic [OUT_CH*DW-1:0]   r_bias, r_wt, r_out;
  logic signed [AW-1:0]   r_acc [OUT_CH];
  logic [DW-1:0]          r_buf [NPIX];
  logic [DW-1:0]          r_pix, r_pix_d;
  logic                   r_out_valid, r_done;
  logic [PA-1:0]          w_rd_addr;
  logic signed [2*DW-1:0] w_prod [OUT_CH];

  assign w_rd_addr = (r_oy + r_ky) * P_IMG_W + r_ox + r_kx;
  assign wt_addr   = (r_state == ST_CONV && r_cnt <= C_LAST_TAP) ? TW'(r_cnt) : '0;
  assign img_ready = (r_state == ST_LOAD_IMG);
  assign busy      = (r_state != ST_IDLE);
  assign out_valid = r_out_valid;
  assign out_data  = r_out;
  assign done      = r_done;

  always_comb begin
    for (int unsigned j = 0; j < OUT_CH; j++) begin
      w_prod[j] = (2*DW)'($signed(r_pix_d)) * (2*DW)'($signed(r_wt[j*DW +: DW]));
    end
  end

  function automatic logic [DW-1:0] f_result(input logic signed [AW-1:0] acc,
                                             input logic [DW-1:0] bias);
    logic signed [AW:0] s;
    logic [DW-1:0]      r;
    s = (AW+1)'(acc >>> FRAC_BITS) + (AW+1)'($signed(bias));
    // In range when every bit above the result's sign bit matches it
    if (s[AW:DW-1] == '0 || s[AW:DW-1] == '1) r = s[DW-1:0];
    else if (s[AW])                           r = {1'b1, {(DW-1){1'b0}}};
    else                                      r = {1'b0, {(DW-1){1'b1}}};
    if (RELU_EN != 0 && r[DW-1]) r = '0;
    return r;
  endfunction

  // Image buffer and tap pipeline: read issued in cycle c, MAC operands ready in c+2
  always_ff @(posedge clk) begin
    if (r_state == ST_LOAD_IMG && img_valid) r_buf[r_waddr] <= img_data;
    r_pix   <= r_buf[w_rd_addr];
    r_pix_d <= r_pix;
    r_wt    <= wt_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_waddr     <= '0;
      r_ox        <= '0;
      r_oy        <= '0;
      r_kx        <= '0;
      r_ky        <= '0;
      r_cnt       <= '0;
      r_bias      <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      for (int unsigned j = 0; j < OUT_CH; j++) r_acc[j] <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_bias  <= bias_in;
            r_waddr <= '0;
            r_state <= ST_LOAD_IMG;
          end
        end
        ST_LOAD_IMG: begin
          if (img_valid) begin
            r_waddr <= r_waddr + 1'b1;
            if (r_waddr == P_LASTPIX) begin
              r_ox    <= '0;
              r_oy    <= '0;
              r_kx    <= '0;
              r_ky    <= '0;
              r_cnt   <= '0;
              r_state <= ST_CONV;
            end
          end
        end
        ST_CONV: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt < C_LAST_TAP) begin
            if (r_kx == P_KM1) begin
              r_kx <= '0;
              r_ky <= r_ky + 1'b1;
            end else begin
              r_kx <= r_kx + 1'b1;
            end
          end
          if (r_cnt == '0) begin
            for (int unsigned j = 0; j < OUT_CH; j++) r_acc[j] <= '0;
          end else if (r_cnt >= CW'(2) && r_cnt <= C_MAC_END) begin
            for (int unsigned j = 0; j < OUT_CH; j++) r_acc[j] <= r_acc[j] + AW'(w_prod[j]);
          end
          if (r_cnt == C_RESULT) begin
            for (int unsigned j = 0; j < OUT_CH; j++)
              r_out[j*DW +: DW] <= f_result(r_acc[j], r_bias[j*DW +: DW]);
            r_out_valid <= 1'b1;
            r_state     <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
            r_kx        <= '0;
            r_ky        <= '0;
            if (r_ox == P_OWM1) begin
              r_ox <= '0;
              if (r_oy == P_OHM1) begin
                r_oy    <= '0;
                r_done  <= 1'b1;
                r_state <= ST_DONE;
              end else begin
                r_oy    <= r_oy + 1'b1;
                r_state <= ST_CONV;
              end
            end else begin
              r_ox    <= r_ox + 1'b1;
              r_state <= ST_CONV;
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv2d_layer.sv
// Scoreboard bench for conv2d_layer (K=3, 5x5 image, 2 channels); two instances
// share stimulus, one with ReLU and one without.
module tb_conv2d_layer;
  logic        clk = 1'b0;
  logic        rst, start, img_valid, out_ready;
  logic [31:0] bias_in, wt_data;
  logic [15:0] img_data;
  logic [3:0]  wt_addr_a, wt_addr_b;
  logic        img_ready_a, img_ready_b, out_valid_a, out_valid_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [31:0] out_a, out_b;

  logic [31:0] rom [9];
  logic [15:0] pix_mem [25];
  logic [31:0] q_a [$];
  logic [31:0] q_b [$];
  int          total = 0, bad = 0;
  int          n_acc = 0, cyc = 0, last_acc = 0;
  int          rdy_mode = 0;
  bit          done_seen = 1'b0, prev_acc = 1'b0;

  always #5 clk = ~clk;

  conv2d_layer #(.DATA_WIDTH(16), .FRAC_BITS(8), .IMG_W(5), .IMG_H(5), .K(3),
                 .OUT_CH(2), .RELU_EN(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .bias_in(bias_in),
    .img_valid(img_valid), .img_ready(img_ready_a), .img_data(img_data),
    .wt_addr(wt_addr_a), .wt_data(wt_data), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_data(out_a), .busy(busy_a), .done(done_a));

  conv2d_layer #(.DATA_WIDTH(16), .FRAC_BITS(8), .IMG_W(5), .IMG_H(5), .K(3),
                 .OUT_CH(2), .RELU_EN(0)) u_dut_nr (
    .clk(clk), .rst(rst), .start(start), .bias_in(bias_in),
    .img_valid(img_valid), .img_ready(img_ready_b), .img_data(img_data),
    .wt_addr(wt_addr_b), .wt_data(wt_data), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_data(out_b), .busy(busy_b), .done(done_b));

  // Weight ROM with one-cycle read latency
  always @(posedge clk) wt_data <= rom[wt_addr_a];

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  // Monitor: compares every presented result with the queue head, pops on acceptance
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (prev_acc) chk("valid_drop_after_accept", {31'b0, out_valid_a}, 32'd0);
      if (out_valid_a) begin
        if (q_a.size() == 0) chk("unexpected_result_a", out_a, 32'hDEAD_BEEF);
        else begin
          chk("out_data_relu", out_a, q_a[0]);
          if (out_ready) begin
            void'(q_a.pop_front());
            if (rdy_mode == 0 && n_acc > 0) chk("result_spacing", cyc - last_acc, 32'd13);
            last_acc = cyc;
            n_acc++;
          end
        end
      end
      if (out_valid_b) begin
        if (q_b.size() == 0) chk("unexpected_result_b", out_b, 32'hDEAD_BEEF);
        else begin
          chk("out_data_norelu", out_b, q_b[0]);
          if (out_ready) void'(q_b.pop_front());
        end
      end
      if (done_a) begin
        chk("results_before_done", n_acc, 32'd9);
        n_acc = 0;
        done_seen = 1'b1;
      end
    end
    prev_acc = !rst && out_valid_a && out_ready;
  end

  task automatic set_const(input logic [15:0] pix, input logic [31:0] wt);
    for (int i = 0; i < 25; i++) pix_mem[i] = pix;
    for (int t = 0; t < 9; t++) rom[t] = wt;
  endtask

  task automatic push_const(input logic [31:0] ea, input logic [31:0] eb);
    for (int i = 0; i < 9; i++) begin
      q_a.push_back(ea);
      q_b.push_back(eb);
    end
  endtask

  task automatic run_pass(input logic [31:0] b);
    int guard;
    done_seen = 1'b0;
    @(posedge clk); #1;
    bias_in = b;
    start   = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    img_valid = 1'b1;
    for (int i = 0; i < 25; i++) begin
      img_data = pix_mem[i];
      guard = 0;
      @(negedge clk);
      while (!img_ready_a && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) chk("img_ready_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
    end
    img_valid = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    while (!done_seen && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk("done_seen", {31'b0, done_seen}, 32'd1);
    chk("queue_a_drained", q_a.size(), 32'd0);
    chk("queue_b_drained", q_b.size(), 32'd0);
    q_a.delete();
    q_b.delete();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_img_ready"}, {31'b0, img_ready_a}, 32'd0);
    chk({tag, "_out_valid"}, {31'b0, out_valid_a}, 32'd0);
    chk({tag, "_busy"},      {31'b0, busy_a},      32'd0);
    chk({tag, "_done"},      {31'b0, done_a},      32'd0);
    chk({tag, "_wt_addr"},   {28'b0, wt_addr_a},   32'd0);
    chk({tag, "_out_data"},  out_a,                32'd0);
    chk({tag, "_nr_ctrl"},   {26'b0, img_ready_b, out_valid_b, busy_b, done_b, wt_addr_b[1:0]}, 32'd0);
    chk({tag, "_nr_data"},   out_b,                32'd0);
  endtask

  initial begin
    int g;
    rst = 1'b1; start = 1'b0; img_valid = 1'b0; out_ready = 1'b1;
    bias_in = '0; img_data = '0;
    set_const(16'h0000, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Scenario 1: unit pixels and weights, per-channel bias
    set_const(16'h0100, 32'h0100_0100);
    push_const(32'h0980_0900, 32'h0980_0900);
    run_pass(32'h0080_0000);
    wait_done();

    // Scenario 2: positive saturation
    set_const(16'h7FFF, 32'h7FFF_7FFF);
    push_const(32'h7FFF_7FFF, 32'h7FFF_7FFF);
    run_pass(32'h0);
    wait_done();

    // Scenario 3: negative result, ReLU vs pass-through
    set_const(16'h0100, 32'hFF00_FF00);
    push_const(32'h0000_0000, 32'hF700_F700);
    run_pass(32'h0);
    wait_done();

    // Negative saturation
    set_const(16'h7FFF, 32'h8000_8000);
    push_const(32'h0000_0000, 32'h8000_8000);
    run_pass(32'h0);
    wait_done();

    // Scenario 4: 10-cycle stall on result 0, then random backpressure
    set_const(16'h0100, 32'h0100_0100);
    push_const(32'h0980_0900, 32'h0980_0900);
    rdy_mode = 2;
    run_pass(32'h0080_0000);
    g = 0;
    while (!out_valid_a && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("first_result_seen", {31'b0, out_valid_a}, 32'd1);
    repeat (10) @(posedge clk);
    rdy_mode = 1;
    wait_done();
    rdy_mode = 0;
    repeat (2) @(posedge clk);

    // Scenario 5: start and img_valid during CONV are ignored
    push_const(32'h0980_0900, 32'h0980_0900);
    run_pass(32'h0080_0000);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; img_valid = 1'b1; img_data = 16'h1234; bias_in = 32'h5555_5555;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    img_valid = 1'b0;
    wait_done();

    // Scenario 6: reset during the 4th position, then a clean pass
    push_const(32'h0980_0900, 32'h0980_0900);
    run_pass(32'h0080_0000);
    g = 0;
    while (n_acc < 3 && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk("three_results_before_reset", n_acc, 32'd3);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_idle("midrst");
    rst = 1'b0;
    q_a.delete();
    q_b.delete();
    n_acc = 0;
    push_const(32'h0980_0900, 32'h0980_0900);
    run_pass(32'h0080_0000);
    wait_done();

    // Spatial pattern: pixel i = i/16; ch0 sums the window, ch1 picks tap 0
    for (int i = 0; i < 25; i++) pix_mem[i] = 16'(i * 16);
    for (int t = 0; t < 9; t++) rom[t] = {(t == 0) ? 16'h0100 : 16'h0000, 16'h0100};
    for (int oy = 0; oy < 3; oy++)
      for (int ox = 0; ox < 3; ox++) begin
        q_a.push_back({16'(16 * (oy * 5 + ox)), 16'(144 * ((oy + 1) * 5 + ox + 1))});
        q_b.push_back({16'(16 * (oy * 5 + ox)), 16'(144 * ((oy + 1) * 5 + ox + 1))});
      end
    run_pass(32'h0);
    wait_done();

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
